if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 97 +++++++++
 tb/tb_if_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC generation, one-cycle-latency imem interface and a
// 2-entry {pc, instr} skid FIFO toward decode, with redirect flush.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  localparam int DATA_W = 32;

  function automatic logic [DATA_W-1:0] align_pc(input logic [DATA_W-1:0] a);
    return a & ~(DATA_W'(3));
  endfunction

  logic [DATA_W-1:0] pc_p0;
  logic              inflight_p1;
  logic              discard_p1;
  logic [DATA_W-1:0] req_pc_p1;
  logic [1:0]        count;
  logic [DATA_W-1:0] fifo_pc    [2];
  logic [DATA_W-1:0] fifo_instr [2];

  logic       fifo_nonempty;
  logic       pop;
  logic       push;
  logic       wr_idx;
  logic [2:0] occ;

  assign fifo_nonempty = (count != 2'd0);
  assign id_valid      = rst_n & fifo_nonempty & ~redirect_valid;
  assign pop           = id_valid & id_ready;
  // Occupancy after this cycle's pop, counting the response still on its way.
  assign occ           = {1'b0, count} + {2'b00, inflight_p1} - {2'b00, pop};
  assign imem_req      = rst_n & ~redirect_valid & (occ < 3'd2);
  assign imem_addr     = rst_n ? pc_p0 : align_pc(RESET_PC);
  assign push          = inflight_p1 & ~discard_p1 & ~redirect_valid;
  assign wr_idx        = (count == 2'd2) | ((count == 2'd1) & ~pop);

  assign id_pc    = (rst_n & fifo_nonempty) ? fifo_pc[0]    : '0;
  assign id_instr = (rst_n & fifo_nonempty) ? fifo_instr[0] : '0;

  // Stage p0 -> p1: request issue, PC advance and redirect
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      pc_p0       <= align_pc(RESET_PC);
      inflight_p1 <= 1'b0;
      discard_p1  <= 1'b0;
      count       <= 2'd0;
    end else begin
      inflight_p1 <= imem_req;
      discard_p1  <= redirect_valid;
      if (redirect_valid) begin
        pc_p0 <= align_pc(redirect_pc);
        count <= 2'd0;
      end else begin
        if (imem_req)
          pc_p0 <= pc_p0 + DATA_W'(4);
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (imem_req)
      req_pc_p1 <= pc_p0;
  end

  // Stage p1 -> FIFO: response capture; head shift and write may coincide
  always_ff @(posedge CLK) begin
    if (!redirect_valid) begin
      if (pop) begin
        fifo_pc[0]    <= fifo_pc[1];
        fifo_instr[0] <= fifo_instr[1];
      end
      if (push) begin
        if (wr_idx) begin
          fifo_pc[1]    <= req_pc_p1;
          fifo_instr[1] <= imem_rdata;
        end else begin
          fifo_pc[0]    <= req_pc_p1;
          fifo_instr[0] <= imem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: fetch-order scoreboard fed from a PC reference model and a
// memory that answers addr ^ 32'hA5A5_A5A5 one cycle after each request.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] K      = 32'hA5A5_A5A5;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] sb[$];
  logic [31:0] fetch_pc = RST_PC;
  logic        pending  = 1'b0;
  logic [31:0] pend_addr = '0;

  logic        s_req, s_vld;
  logic [31:0] s_addr, s_pc, s_instr;

  // One clock: drive inputs, check outputs at the falling edge against the
  // reference model, then let the memory answer the sampled request.
  task automatic cycle(input logic rstn, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic        exp_vld, exp_req, pop;
    int          occ;
    logic [31:0] e;
    rst_n = rstn; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
    @(negedge CLK);
    s_req = imem_req; s_addr = imem_addr; s_vld = id_valid; s_pc = id_pc; s_instr = id_instr;
    occ = sb.size();
    exp_vld = rstn && !rv && (occ > (pending ? 1 : 0));
    n_cmp++;
    if (s_vld !== exp_vld) begin
      n_fail++; $display("FAIL id_valid: got %b want %b at %0t", s_vld, exp_vld, $time);
    end
    pop = exp_vld && rdy;
    if (pop && s_vld) begin
      e = sb.pop_front();
      n_cmp++;
      if (s_pc !== e) begin
        n_fail++; $display("FAIL id_pc: got %h want %h at %0t", s_pc, e, $time);
      end
      n_cmp++;
      if (s_instr !== (e ^ K)) begin
        n_fail++; $display("FAIL id_instr: got %h want %h at %0t", s_instr, e ^ K, $time);
      end
    end
    exp_req = rstn && !rv && ((occ - (pop ? 1 : 0)) < 2);
    n_cmp++;
    if (s_req !== exp_req) begin
      n_fail++; $display("FAIL imem_req: got %b want %b at %0t", s_req, exp_req, $time);
    end
    if (!rstn) begin
      n_cmp++;
      if (s_addr !== RST_PC || s_pc !== 32'h0 || s_instr !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: got addr %h pc %h instr %h want %h/0/0", s_addr, s_pc, s_instr, RST_PC);
      end
      sb.delete(); fetch_pc = RST_PC;
    end else if (rv) begin
      sb.delete(); fetch_pc = rpc & ~32'h3;
    end else if (s_req) begin
      n_cmp++;
      if (s_addr !== fetch_pc) begin
        n_fail++; $display("FAIL imem_addr: got %h want %h at %0t", s_addr, fetch_pc, $time);
      end
      sb.push_back(fetch_pc);
      fetch_pc = fetch_pc + 32'd4;
    end
    n_cmp++;
    if (sb.size() > 2) begin
      n_fail++; $display("FAIL occupancy: got %0d want <=2", sb.size());
    end
    pending = s_req; pend_addr = s_addr;
    @(posedge CLK); #1;
    imem_rdata = pending ? (pend_addr ^ K) : 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_stream();
    int first_vld = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (s_req !== 1'b1 || s_addr !== 32'(4 * i)) begin
        n_fail++; $display("FAIL stream_addr: got req %b addr %h want 1/%h", s_req, s_addr, 32'(4 * i));
      end
      if (s_vld && first_vld < 0) first_vld = i;
    end
    n_cmp++;
    if (first_vld != 2) begin
      n_fail++; $display("FAIL first_valid: got cycle %0d want 2", first_vld);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      if (k == 0) held = s_pc;
      n_cmp++;
      if (s_vld !== 1'b1 || s_pc !== held || s_instr !== (held ^ K)) begin
        n_fail++; $display("FAIL stall_head: got vld %b pc %h instr %h want 1/%h/%h", s_vld, s_pc, s_instr, held, held ^ K);
      end
      if (k >= 1) begin
        n_cmp++;
        if (s_req !== 1'b0) begin
          n_fail++; $display("FAIL stall_req: got %b want 0", s_req);
        end
      end
    end
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_redirect();
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_1003, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (s_req !== 1'b1 || s_addr !== 32'h0000_1000) begin
      n_fail++; $display("FAIL redirect_addr: got req %b addr %h want 1/00001000", s_req, s_addr);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (s_vld !== 1'b1 || s_pc !== 32'h0000_1000) begin
      n_fail++; $display("FAIL redirect_first: got vld %b pc %h want 1/00001000", s_vld, s_pc);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_2000, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_3000, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (s_addr !== 32'h0000_3000) begin
      n_fail++; $display("FAIL redirect_held: got %h want 00003000", s_addr);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_wrap();
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (s_req !== 1'b1 || s_addr !== want[i]) begin
        n_fail++; $display("FAIL wrap_addr%0d: got req %b addr %h want 1/%h", i, s_req, s_addr, want[i]);
      end
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (s_vld !== 1'b0 || s_req !== 1'b1 || s_addr !== RST_PC) begin
      n_fail++; $display("FAIL midreset_restart: got vld %b req %b addr %h want 0/1/%h", s_vld, s_req, s_addr, RST_PC);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (s_vld !== 1'b0) begin
      n_fail++; $display("FAIL midreset_drop: got vld %b pc %h want 0", s_vld, s_pc);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (s_vld !== 1'b1 || s_pc !== RST_PC) begin
      n_fail++; $display("FAIL midreset_first: got vld %b pc %h want 1/%h", s_vld, s_pc, RST_PC);
    end
  endtask

  task automatic test_random();
    logic rv, rdy;
    for (int i = 0; i < 10000; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 31) == 0);
      cycle(1'b1, rv, $urandom, rdy);
    end
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0; imem_rdata = '0;
    @(posedge CLK); #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
